seg_count_ctrl: RTL and testbench

Sequencing controller for the single-digit decade counter and 7-segment display path on the FPGA board. It owns the digit state and a programmable prescaler that generates the count tick. It arbitrates between run/stop/step/clear/load commands and the free-running tick, and drives registered active-low segment outputs. It replaces the ad-hoc delay-counter sequencing in per-assignment display modules.

---
 rtl/seg_count_ctrl_if.sv | 33 +++
 rtl/seg_count_ctrl.sv | 131 +++++++++++++
 tb/tb_seg_count_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/seg_count_ctrl_if.sv
// Command/status bundle between a board-level sequencer and seg_count_ctrl.
// The dir member exists only when SEG_COUNT_CTRL_DOWN_EN is defined.
interface seg_count_ctrl_if;
  logic       start;
  logic       stop;
  logic       step;
  logic       clear;
  logic       load;
  logic [3:0] load_val;
`ifdef SEG_COUNT_CTRL_DOWN_EN
  logic       dir;
`endif
  logic [3:0] digit;
  logic [6:0] seg;
  logic       carry;
  logic       running;

  modport master (
    output start, stop, step, clear, load, load_val,
`ifdef SEG_COUNT_CTRL_DOWN_EN
    output dir,
`endif
    input  digit, seg, carry, running
  );

  modport slave (
    input  start, stop, step, clear, load, load_val,
`ifdef SEG_COUNT_CTRL_DOWN_EN
    input  dir,
`endif
    output digit, seg, carry, running
  );
endinterface

// File: rtl/seg_count_ctrl.sv
// Decade counter sequencer with programmable tick prescaler and registered active-low 7-seg output.
// Optional down-counting (dir input) is enabled by defining SEG_COUNT_CTRL_DOWN_EN.
module seg_count_ctrl #(
  parameter int unsigned TICK_DIV  = 20000000,
  parameter int unsigned MAX_DIGIT = 9
) (
  input  logic             clk,
  input  logic             rst,
  seg_count_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE
  } state_e;

  localparam logic [26:0] TICK_LAST = 27'(TICK_DIV - 1);
  localparam logic [3:0]  MAX_D     = 4'(MAX_DIGIT);

  state_e      state_q, state_d;
  logic [26:0] presc_q, presc_d;
  logic [3:0]  digit_q, digit_d;
  logic        carry_q, carry_d;
  logic [6:0]  seg_q, seg_d;
  logic        tick;
  logic        count_down;

`ifdef SEG_COUNT_CTRL_DOWN_EN
  assign count_down = bus.dir;
`else
  assign count_down = 1'b0;
`endif

  // stop takes precedence over start in every state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.start && !bus.stop) state_d = ST_RUN;
      ST_RUN:   if (bus.stop) state_d = ST_PAUSE;
      ST_PAUSE: begin
        if (bus.stop)       state_d = ST_IDLE;
        else if (bus.start) state_d = ST_RUN;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // Prescaler advances on the current RUN state, so the stop cycle still counts;
  // it holds through PAUSE and is zero whenever the block sits in IDLE.
  always_comb begin
    tick    = 1'b0;
    presc_d = presc_q;
    if (state_q == ST_RUN) begin
      if (presc_q == TICK_LAST) begin
        presc_d = '0;
        tick    = 1'b1;
      end else begin
        presc_d = presc_q + 27'd1;
      end
    end else if (state_q == ST_IDLE || bus.stop) begin
      presc_d = '0;
    end
    if (bus.clear) presc_d = '0;
  end

  always_comb begin
    digit_d = digit_q;
    carry_d = 1'b0;
    if (bus.clear) begin
      digit_d = '0;
    end else if (bus.load) begin
      digit_d = (bus.load_val > MAX_D) ? MAX_D : bus.load_val;
    end else if (bus.step || tick) begin
      if (count_down) begin
        if (digit_q == 4'd0) begin
          digit_d = MAX_D;
          carry_d = 1'b1;
        end else begin
          digit_d = digit_q - 4'd1;
        end
      end else begin
        if (digit_q >= MAX_D) begin
          digit_d = '0;
          carry_d = 1'b1;
        end else begin
          digit_d = digit_q + 4'd1;
        end
      end
    end
  end

  always_comb begin
    seg_d = 7'b1111111;
    case (digit_q)
      4'd0: seg_d = 7'b0000001;
      4'd1: seg_d = 7'b1001111;
      4'd2: seg_d = 7'b0010010;
      4'd3: seg_d = 7'b0000110;
      4'd4: seg_d = 7'b1001100;
      4'd5: seg_d = 7'b0100100;
      4'd6: seg_d = 7'b0100000;
      4'd7: seg_d = 7'b0001111;
      4'd8: seg_d = 7'b0000000;
      4'd9: seg_d = 7'b0000100;
      default: seg_d = 7'b1111111;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      digit_q <= '0;
      carry_q <= 1'b0;
      seg_q   <= 7'b0000001;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      digit_q <= digit_d;
      carry_q <= carry_d;
      seg_q   <= seg_d;
    end
  end

  assign bus.digit   = digit_q;
  assign bus.seg     = seg_q;
  assign bus.carry   = carry_q;
  assign bus.running = (state_q == ST_RUN);

endmodule

// File: tb/tb_seg_count_ctrl.sv
// Directed self-checking bench for seg_count_ctrl with TICK_DIV=4, MAX_DIGIT=9.
// Define SEG_COUNT_CTRL_DOWN_EN to also exercise down-counting.
module tb_seg_count_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  seg_count_ctrl_if bus();

  seg_count_ctrl #(
    .TICK_DIV  (4),
    .MAX_DIGIT (9)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [6:0] seg_exp(input int d);
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.stop = 1'b1;
    cyc();
    bus.stop = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.step = 1'b0;
    bus.clear = 1'b0;
    bus.load = 1'b0;
    bus.load_val = 4'd0;
`ifdef SEG_COUNT_CTRL_DOWN_EN
    bus.dir = 1'b0;
`endif

    // reset values
    do_reset();
    check("rst_digit", bus.digit, 0);
    check("rst_seg", bus.seg, 7'b0000001);
    check("rst_running", bus.running, 0);
    check("rst_carry", bus.carry, 0);

    // run and wrap: digit i/4 mod 10, carry at edge 40, seg one edge behind
    pulse_start();
    check("run_running", bus.running, 1);
    check("run_digit0", bus.digit, 0);
    for (int i = 1; i <= 40; i++) begin
      cyc();
      check("run_digit", bus.digit, (i / 4) % 10);
      check("run_carry", bus.carry, (i == 40) ? 1 : 0);
      check("run_seg", bus.seg, seg_exp(((i - 1) / 4) % 10));
    end
    pulse_stop();
    check("run_carry_end", bus.carry, 0);
    check("stop1_running", bus.running, 0);
    pulse_stop();
    check("stop2_running", bus.running, 0);

    // pause and resume keeps prescaler
    do_reset();
    pulse_start();
    repeat (5) cyc();
    pulse_stop();
    check("pause_running", bus.running, 0);
    check("pause_digit", bus.digit, 1);
    for (int i = 0; i < 10; i++) begin
      cyc();
      check("pause_hold", bus.digit, 1);
    end
    pulse_start();
    check("resume_running", bus.running, 1);
    check("resume_digit", bus.digit, 1);
    cyc();
    check("resume_p1", bus.digit, 1);
    cyc();
    check("resume_p2", bus.digit, 2);
    pulse_stop();
    check("rstop1_running", bus.running, 0);
    pulse_stop();
    pulse_start();
    repeat (3) cyc();
    check("idle_restart_p3", bus.digit, 2);
    cyc();
    check("idle_restart_p4", bus.digit, 3);
    pulse_stop();
    pulse_stop();

    // command priority
    do_reset();
    bus.load = 1'b1; bus.load_val = 4'd5;
    cyc();
    bus.load = 1'b0;
    check("load5", bus.digit, 5);
    bus.clear = 1'b1; bus.load = 1'b1; bus.step = 1'b1; bus.load_val = 4'd5;
    cyc();
    bus.clear = 1'b0; bus.load = 1'b0; bus.step = 1'b0;
    check("clr_prio_digit", bus.digit, 0);
    check("clr_prio_carry", bus.carry, 0);
    bus.load = 1'b1; bus.load_val = 4'd12;
    cyc();
    bus.load = 1'b0;
    check("load_clamp", bus.digit, 9);
    check("load_carry", bus.carry, 0);
    cyc();
    check("seg9", bus.seg, 7'b0000100);
    bus.step = 1'b1;
    cyc();
    bus.step = 1'b0;
    check("step_wrap_digit", bus.digit, 0);
    check("step_wrap_carry", bus.carry, 1);
    cyc();
    check("carry_width", bus.carry, 0);
    check("seg0_after_wrap", bus.seg, 7'b0000001);

    // step coinciding with tick: one increment, prescaler still wraps
    do_reset();
    pulse_start();
    repeat (3) cyc();
    bus.step = 1'b1;
    cyc();
    bus.step = 1'b0;
    check("step_tick_digit", bus.digit, 1);
    repeat (3) cyc();
    check("step_tick_hold", bus.digit, 1);
    cyc();
    check("step_tick_next", bus.digit, 2);

    // start + stop together in IDLE
    do_reset();
    bus.start = 1'b1; bus.stop = 1'b1;
    cyc();
    bus.start = 1'b0; bus.stop = 1'b0;
    check("ss_running", bus.running, 0);
    repeat (6) cyc();
    check("ss_digit", bus.digit, 0);
    check("ss_running_late", bus.running, 0);

    // reset mid-run at digit 7 overrides coincident commands
    do_reset();
    pulse_start();
    repeat (28) cyc();
    check("mid_digit7", bus.digit, 7);
    cyc();
    check("mid_seg7", bus.seg, 7'b0001111);
    rst = 1'b1; bus.step = 1'b1; bus.load = 1'b1; bus.load_val = 4'd3;
    cyc();
    rst = 1'b0; bus.step = 1'b0; bus.load = 1'b0;
    check("mid_rst_digit", bus.digit, 0);
    check("mid_rst_seg", bus.seg, 7'b0000001);
    check("mid_rst_running", bus.running, 0);
    check("mid_rst_carry", bus.carry, 0);
    repeat (5) cyc();
    check("mid_rst_idle", bus.digit, 0);

`ifdef SEG_COUNT_CTRL_DOWN_EN
    // down counting borrow
    do_reset();
    bus.dir = 1'b1;
    bus.step = 1'b1;
    cyc();
    bus.step = 1'b0;
    check("down_wrap_digit", bus.digit, 9);
    check("down_wrap_carry", bus.carry, 1);
    bus.step = 1'b1;
    cyc();
    bus.step = 1'b0;
    check("down_digit8", bus.digit, 8);
    check("down_carry0", bus.carry, 0);
    bus.dir = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
